// File: rtl/bpsk_pkg.sv
// Shared defaults and types for the BPSK carrier generator.
// Quarter-wave sine table contents are computed here at elaboration time.
package bpsk_pkg;

  localparam int ACC_W_DEF      = 32;
  localparam int DATA_W_DEF     = 16;
  localparam int LUT_ADDR_W_DEF = 8;

  localparam logic [ACC_W_DEF-1:0] HALF_TURN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef logic [1:0]                    quad_t;
  typedef logic signed [DATA_W_DEF-1:0]  sample_t;

  // round((2^(dw-1)-1) * sin(pi/2 * (i+0.5) / 2^aw)); the Taylor series is
  // used so only basic real arithmetic is needed during elaboration.
  function automatic int quarter_sine(input int i, input int aw, input int dw);
    real x;
    real term;
    real acc;
    real amp;
    x    = 1.5707963267948966 * (real'(i) + 0.5) / real'(1 << aw);
    term = x;
    acc  = x;
    for (int k = 1; k < 10; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    amp = real'((1 << (dw - 1)) - 1);
    return $rtoi(amp * acc + 0.5);
  endfunction

endpackage

// File: rtl/bpsk_carrier_gen_sine_quarter_lut.sv
// Registered quarter-wave sine ROM: one-cycle read latency, non-negative amplitudes.
module sine_quarter_lut
  import bpsk_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_amp
);

  logic [DATA_W-1:0] w_rom [2**ADDR_W];
  logic [DATA_W-1:0] r_amp;

  for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_rom
    localparam logic [DATA_W-1:0] AMP = DATA_W'(quarter_sine(gi, ADDR_W, DATA_W));
    assign w_rom[gi] = AMP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_amp <= '0;
    else        r_amp <= w_rom[i_addr];
  end

  assign o_amp = r_amp;

endmodule

// File: rtl/bpsk_carrier_gen.sv
// NCO + quarter-wave LUT BPSK carrier, 3-stage pipeline, one sample per clock.
// Optional BPSK_ZC_ALIGN_EN defers phase changes to the next carrier wrap.
module bpsk_carrier_gen
  import bpsk_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     gen_en,
  input  logic                     phase_ctrl,
  input  logic [ACC_W-1:0]         ftw,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic                     flip_strobe
);

  localparam int IDX_W = LUT_ADDR_W + 2;

  // Stage 1: NCO
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      r_ftw_q;
  logic                  r_ph_eff;
  logic [IDX_W-1:0]      r_p1;
  logic                  r_ph1;
  logic                  r_v1;
  logic [ACC_W:0]        w_sum;
  logic [IDX_W-1:0]      w_idx;

  // Stage 2: LUT read
  quad_t                 w_quad;
  logic [LUT_ADDR_W-1:0] w_low;
  logic [LUT_ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]     w_amp;
  logic signed [DATA_W-1:0] w_amp_s;
  logic                  r_neg2;
  logic                  r_ph2;
  logic                  r_v2;

  // Stage 3: output
  logic signed [DATA_W-1:0] r_sample;
  logic                  r_valid;
  logic                  r_strobe;
  logic                  r_last_ph;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_ftw_q};
  // Adding a half turn only flips the accumulator MSB.
  assign w_idx = {r_acc[ACC_W-1] ^ r_ph_eff, r_acc[ACC_W-2 -: IDX_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_ftw_q  <= '0;
      r_ph_eff <= 1'b0;
      r_p1     <= '0;
      r_ph1    <= 1'b0;
      r_v1     <= 1'b0;
    end else if (!gen_en) begin
      r_ftw_q  <= ftw;
      r_acc    <= '0;
      r_ph_eff <= phase_ctrl;
      r_v1     <= 1'b0;
    end else begin
      r_acc <= w_sum[ACC_W-1:0];
      r_p1  <= w_idx;
      r_ph1 <= r_ph_eff;
      r_v1  <= 1'b1;
`ifdef BPSK_ZC_ALIGN_EN
      // carry out of the accumulator marks a carrier cycle boundary
      if (w_sum[ACC_W]) r_ph_eff <= phase_ctrl;
`else
      r_ph_eff <= phase_ctrl;
`endif
    end
  end

  assign w_quad = r_p1[IDX_W-1 -: 2];
  assign w_low  = r_p1[LUT_ADDR_W-1:0];
  assign w_addr = w_quad[0] ? ~w_low : w_low;

  sine_quarter_lut #(
    .ADDR_W (LUT_ADDR_W),
    .DATA_W (DATA_W)
  ) u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_addr (w_addr),
    .o_amp  (w_amp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg2 <= 1'b0;
      r_ph2  <= 1'b0;
      r_v2   <= 1'b0;
    end else begin
      r_neg2 <= w_quad[1];
      r_ph2  <= r_ph1;
      r_v2   <= r_v1;
    end
  end

  assign w_amp_s = w_amp;

  // The strobe needs a valid predecessor, so the first sample of a burst never flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
      r_last_ph <= 1'b0;
    end else if (r_v2) begin
      r_sample  <= r_neg2 ? -w_amp_s : w_amp_s;
      r_valid   <= 1'b1;
      r_strobe  <= r_valid && (r_ph2 != r_last_ph);
      r_last_ph <= r_ph2;
    end else begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign flip_strobe  = r_strobe;

endmodule

// File: tb/tb_bpsk_carrier_gen.sv
// Directed-sequence bench with a sine-formula scoreboard for bpsk_carrier_gen.
module tb_bpsk_carrier_gen;
  import bpsk_pkg::*;

  localparam logic [31:0] F_Q = 32'h4000_0000;
  localparam logic [31:0] F_H = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gen_en = 1'b0;
  logic        phase_ctrl = 1'b0;
  logic [31:0] ftw = '0;
  sample_t     sample_out;
  logic        sample_valid;
  logic        flip_strobe;

  always #5 clk = ~clk;

  bpsk_carrier_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gen_en       (gen_en),
    .phase_ctrl   (phase_ctrl),
    .ftw          (ftw),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .flip_strobe  (flip_strobe)
  );

  typedef struct {
    logic    v;
    sample_t s;
    logic    ph;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_acc = '0;
  logic [31:0] m_ftw = '0;
  logic        m_ph = 1'b0;
  logic        m_prev_v = 1'b0;
  logic        m_last_ph = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Expected sample straight from the full-wave sine at the phase midpoint.
  function automatic sample_t model_sample(input logic [31:0] p);
    int  idx;
    int  mag;
    real a;
    idx = int'(p[31:22]);
    a   = 32767.0 * $sin(6.283185307179586 * (real'(idx) + 0.5) / 1024.0);
    mag = (a >= 0.0) ? $rtoi(a + 0.5) : $rtoi(-a + 0.5);
    return (a >= 0.0) ? 16'(mag) : 16'(-mag);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_smp"}, sample_out, 0);
    check({tag, "_vld"}, sample_valid, 0);
    check({tag, "_stb"}, flip_strobe, 0);
  endtask

  task automatic step(input logic en, input logic ph, input logic [31:0] f);
    exp_t        e;
    logic [32:0] sum;
    logic        stb;
    gen_en     = en;
    phase_ctrl = ph;
    ftw        = f;
    @(posedge clk);
    if (en) begin
      e.v  = 1'b1;
      e.ph = m_ph;
      e.s  = model_sample(m_acc + (m_ph ? HALF_TURN : 32'h0));
      sum  = {1'b0, m_acc} + {1'b0, m_ftw};
      m_acc = sum[31:0];
`ifdef BPSK_ZC_ALIGN_EN
      if (sum[32]) m_ph = ph;
`else
      m_ph = ph;
`endif
    end else begin
      e.v   = 1'b0;
      e.s   = '0;
      e.ph  = 1'b0;
      m_ftw = f;
      m_acc = '0;
      m_ph  = ph;
    end
    sb.push_back(e);
    #1;
    if (sb.size() == 3) begin
      e   = sb.pop_front();
      stb = e.v && m_prev_v && (e.ph != m_last_ph);
      check("sb_smp", sample_out, e.s);
      check("sb_vld", sample_valid, e.v);
      check("sb_stb", flip_strobe, stb);
      if (e.v) m_last_ph = e.ph;
      m_prev_v = e.v;
    end else begin
      check_idle("fill");
    end
  endtask

  initial begin
    #3;
    check_idle("rst");
    #9 rst_n = 1'b1;

    // idle after reset
    repeat (5) step(1'b0, 1'b0, F_Q);

    // quarter-rate tone
    step(1'b1, 1'b0, F_Q);
    step(1'b1, 1'b0, F_Q);
    step(1'b1, 1'b0, F_Q);
    check("qr_v0", sample_valid, 1);
    check("qr_s0", sample_out, 101);
    step(1'b1, 1'b0, F_Q);
    check("qr_s1", sample_out, 32767);
    step(1'b1, 1'b0, F_Q);
    check("qr_s2", sample_out, -101);
    step(1'b1, 1'b0, F_Q);
    check("qr_s3", sample_out, -32767);
    repeat (4) step(1'b1, 1'b0, F_Q);

    // phase flip: new burst, phase_ctrl rises before the third sample
    step(1'b0, 1'b0, F_Q);
    step(1'b1, 1'b0, F_Q);
    step(1'b1, 1'b1, F_Q);
    step(1'b1, 1'b1, F_Q);
    step(1'b1, 1'b1, F_Q);
    step(1'b1, 1'b1, F_Q);
`ifndef BPSK_ZC_ALIGN_EN
    check("flip_s2", sample_out, 101);
    check("flip_stb", flip_strobe, 1);
`endif
    step(1'b1, 1'b1, F_Q);
`ifndef BPSK_ZC_ALIGN_EN
    check("flip_s3", sample_out, 32767);
    check("flip_stb_once", flip_strobe, 0);
`endif
    repeat (6) step(1'b1, 1'b1, F_Q);

    // mid-cycle toggles, including a double toggle inside one carrier period
    step(1'b1, 1'b0, F_Q);
    step(1'b1, 1'b0, F_Q);
    repeat (4) step(1'b1, 1'b0, F_Q);
    step(1'b1, 1'b1, F_Q);
    step(1'b1, 1'b0, F_Q);
    repeat (6) step(1'b1, 1'b0, F_Q);
    step(1'b1, 1'b1, F_Q);
    repeat (6) step(1'b1, 1'b1, F_Q);

    // one-cycle enable gap with a new tuning word
    step(1'b0, 1'b0, F_H);
    step(1'b1, 1'b0, F_H);
    step(1'b1, 1'b0, F_H);
    check("gap_vld", sample_valid, 0);
    step(1'b1, 1'b0, F_H);
    check("gap_s0", sample_out, 101);
    check("gap_stb", flip_strobe, 0);
    step(1'b1, 1'b0, F_H);
    check("gap_s1", sample_out, -101);
    step(1'b1, 1'b0, F_H);
    check("gap_s2", sample_out, 101);

    // gen_en toggling every cycle
    for (int i = 0; i < 8; i++) step(1'(i % 2), 1'(i / 4), F_Q);
    repeat (3) step(1'b0, 1'b0, F_Q);

    // async reset mid-burst
    repeat (5) step(1'b1, 1'b0, F_Q);
    #2 rst_n = 1'b0;
    #1;
    check_idle("arst");
    sb.delete();
    m_acc = '0; m_ftw = '0; m_ph = 1'b0; m_prev_v = 1'b0; m_last_ph = 1'b0;
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, F_Q);
    step(1'b1, 1'b0, F_Q);
    step(1'b1, 1'b0, F_Q);
    check("arst_v0", sample_valid, 1);
    check("arst_s0", sample_out, 101);
    repeat (3) step(1'b1, 1'b0, F_Q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
